gpu_line_rasterizer: RTL

Stage directly downstream of the GPU command decoder. Consumes the line endpoints, the colour and the draw_line strobe, and rasterizes the line with integer Bresenham. Emits one pixel write per accepted cycle to the frame-buffer writer over a valid/ready handshake. Returns a one-cycle finished pulse to the decoder so it can leave its command state.

---
 rtl/gpu_line_rasterizer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/gpu_line_rasterizer.sv
// gpu_line_rasterizer: integer Bresenham line rasterizer between the command
// decoder and the frame-buffer writer. Endpoints are captured on the
// draw_line strobe, colour one cycle later, then one pixel is emitted per
// accepted valid/ready handshake, followed by a one-cycle finished pulse.
// Optional build macro GPU_LINE_CLIP_EN: pixels outside H_RES x V_RES are
// suppressed and skipped at one per cycle without waiting for px_ready_i.
module gpu_line_rasterizer #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int CW    = 8,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [XW-1:0]   x1_i,
  input  logic [YW-1:0]   y1_i,
  input  logic [XW-1:0]   x2_i,
  input  logic [YW-1:0]   y2_i,
  input  logic [CW-1:0]   r_i,
  input  logic [CW-1:0]   g_i,
  input  logic [CW-1:0]   b_i,
  input  logic            draw_line_i,
  input  logic            px_ready_i,
  output logic [XW-1:0]   px_x_o,
  output logic [YW-1:0]   px_y_o,
  output logic [3*CW-1:0] px_color_o,
  output logic            px_valid_o,
  output logic            busy_o,
  output logic            finished_o
);

  // Signed working width: one extra bit for sign, one for the 2*err headroom.
  localparam int SW = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [SW-1:0] ZERO = '0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

  state_t                 state_reg, state_next;
  logic [XW-1:0]          x1_reg, x1_next, x2_reg, x2_next;
  logic [YW-1:0]          y1_reg, y1_next, y2_reg, y2_next;
  logic [3*CW-1:0]        color_reg, color_next;
  logic [XW-1:0]          x_reg, x_next;
  logic [YW-1:0]          y_reg, y_next;
  logic signed [SW-1:0]   err_reg, err_next;
  logic signed [SW-1:0]   dx_reg, dx_next;
  logic signed [SW-1:0]   dy_reg, dy_next;
  logic                   sx_neg_reg, sx_neg_next;
  logic                   sy_neg_reg, sy_neg_next;

  logic signed [SW-1:0]   x1_s, x2_s, y1_s, y2_s;
  logic signed [SW-1:0]   dx_raw, dy_raw, dx_abs, dy_negabs;
  logic signed [SW:0]     e2, dx_ext, dy_ext;
  logic                   step_x, step_y, at_end, visible, advance;

  // Zero-extended endpoints in the signed working width.
  assign x1_s = $signed({{(SW-XW){1'b0}}, x1_reg});
  assign x2_s = $signed({{(SW-XW){1'b0}}, x2_reg});
  assign y1_s = $signed({{(SW-YW){1'b0}}, y1_reg});
  assign y2_s = $signed({{(SW-YW){1'b0}}, y2_reg});

  assign dx_raw    = x2_s - x1_s;
  assign dy_raw    = y2_s - y1_s;
  assign dx_abs    = dx_raw[SW-1] ? -dx_raw : dx_raw;
  assign dy_negabs = dy_raw[SW-1] ? dy_raw : -dy_raw;

  // Both step decisions are taken against the same (old) error term.
  assign e2     = $signed({err_reg, 1'b0});
  assign dx_ext = {dx_reg[SW-1], dx_reg};
  assign dy_ext = {dy_reg[SW-1], dy_reg};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);
  assign at_end = (x_reg == x2_reg) && (y_reg == y2_reg);

`ifdef GPU_LINE_CLIP_EN
  assign visible = (int'(x_reg) < H_RES) && (int'(y_reg) < V_RES);
`else
  assign visible = 1'b1;
`endif

  // Off-screen pixels advance on their own; visible ones wait for ready.
  assign advance = (state_reg == S_DRAW) && (visible ? px_ready_i : 1'b1);

  assign px_x_o     = x_reg;
  assign px_y_o     = y_reg;
  assign px_color_o = color_reg;
  assign px_valid_o = (state_reg == S_DRAW) && visible;
  assign busy_o     = (state_reg != S_IDLE);
  assign finished_o = (state_reg == S_DONE);

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_next  = state_reg;
    x1_next     = x1_reg;
    y1_next     = y1_reg;
    x2_next     = x2_reg;
    y2_next     = y2_reg;
    color_next  = color_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    err_next    = err_reg;
    dx_next     = dx_reg;
    dy_next     = dy_reg;
    sx_neg_next = sx_neg_reg;
    sy_neg_next = sy_neg_reg;
    case (state_reg)
      S_IDLE: begin
        if (draw_line_i) begin
          x1_next    = x1_i;
          y1_next    = y1_i;
          x2_next    = x2_i;
          y2_next    = y2_i;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        color_next  = {r_i, g_i, b_i};
        dx_next     = dx_abs;
        dy_next     = dy_negabs;
        sx_neg_next = !(x1_reg < x2_reg);
        sy_neg_next = !(y1_reg < y2_reg);
        err_next    = dx_abs + dy_negabs;
        x_next      = x1_reg;
        y_next      = y1_reg;
        state_next  = S_DRAW;
      end
      S_DRAW: begin
        if (advance) begin
          if (at_end) begin
            state_next = S_DONE;
          end else begin
            err_next = err_reg + (step_x ? dy_reg : ZERO) + (step_y ? dx_reg : ZERO);
            if (step_x) x_next = sx_neg_reg ? x_reg - 1'b1 : x_reg + 1'b1;
            if (step_y) y_next = sy_neg_reg ? y_reg - 1'b1 : y_reg + 1'b1;
          end
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any line in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg  <= S_IDLE;
      x1_reg     <= '0;
      y1_reg     <= '0;
      x2_reg     <= '0;
      y2_reg     <= '0;
      color_reg  <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      err_reg    <= '0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      sx_neg_reg <= 1'b0;
      sy_neg_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x1_reg     <= x1_next;
      y1_reg     <= y1_next;
      x2_reg     <= x2_next;
      y2_reg     <= y2_next;
      color_reg  <= color_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      err_reg    <= err_next;
      dx_reg     <= dx_next;
      dy_reg     <= dy_next;
      sx_neg_reg <= sx_neg_next;
      sy_neg_reg <= sy_neg_next;
    end
  end

endmodule
